cc_mem_rd_responder: RTL



---
 rtl/cc_mem_rd_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cc_mem_rd_responder.sv
`timescale 1ns/1ps
// AXI AR/R slave that serves in-order bursts from a synchronous-read 64-bit word memory.
// Requests are queued, classified, then streamed out after a fixed access latency.
module cc_mem_rd_responder #(
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        arid_i,
    input  logic [31:0]       araddr_i,
    input  logic [3:0]        arlen_i,
    input  logic [2:0]        arsize_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [3:0]        rid_o,
    output logic [63:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              mem_rden_o,
    output logic [MEM_AW-1:0] mem_raddr_o,
    input  logic [63:0]       mem_rdata_i
);

    localparam int unsigned PW = $clog2(REQ_DEPTH);
    // The pop cycle counts as the first latency cycle, so WAIT lasts LATENCY-1 cycles.
    localparam logic [7:0] WaitLoad = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    typedef struct packed {
        logic [3:0]        id;
        logic [MEM_AW-1:0] word;
        logic [3:0]        len;
        logic [1:0]        burst;
        logic [1:0]        resp;
    } req_t;

    // ---------------- request queue ----------------
    req_t          queue_q [REQ_DEPTH];
    req_t          req_in;
    req_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop, full, empty;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^araddr_i[2:0];
    assign full      = (count_q == REQ_DEPTH[PW:0]);
    assign empty     = (count_q == '0);
    assign arready_o = !full;
    assign push      = arvalid_i && arready_o;
    assign head      = queue_q[rd_ptr_q];

    // Classification is a pure function of the request, so it is resolved once at push.
    always_comb begin
        logic wrap_len_ok;
        logic slverr;
        logic decerr;
        wrap_len_ok  = (arlen_i == 4'd1) || (arlen_i == 4'd3) ||
                       (arlen_i == 4'd7) || (arlen_i == 4'd15);
        slverr       = (arsize_i != 3'b011) || (arburst_i == 2'b11) ||
                       ((arburst_i == 2'b10) && !wrap_len_ok);
        decerr       = (araddr_i[31:MEM_AW+3] != '0);
        req_in       = '0;
        req_in.id    = arid_i;
        req_in.word  = araddr_i[MEM_AW+2:3];
        req_in.len   = arlen_i;
        req_in.burst = arburst_i;
        req_in.resp  = slverr ? 2'b10 : (decerr ? 2'b11 : 2'b00);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wr_ptr_q] <= req_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- burst control ----------------
    state_e            state_q, state_d;
    logic [3:0]        id_q;
    logic [1:0]        resp_q;
    logic [1:0]        burst_q;
    logic [MEM_AW-1:0] waddr_q, wmask_q, waddr_next;
    logic [4:0]        beats_q;
    logic [7:0]        wait_q;
    logic              issue, r_free;

    logic              p1_valid_q, p1_last_q;
    logic              sk_valid_q, sk_last_q;
    logic [63:0]       sk_data_q, beat_data;

    assign r_free = !rvalid_o || rready_i;
    // A beat in the skid slot already owns the next R slot, so hold issue until it drains.
    assign issue  = (state_q == StBurst) && (beats_q != 5'd0) && r_free && !sk_valid_q;
    assign mem_rden_o  = issue && (resp_q == 2'b00);
    assign mem_raddr_o = waddr_q;
    assign beat_data   = (resp_q == 2'b00) ? mem_rdata_i : 64'd0;

    always_comb begin
        unique case (burst_q)
            2'b00:   waddr_next = waddr_q;
            2'b10:   waddr_next = (waddr_q & ~wmask_q) | ((waddr_q + MEM_AW'(1)) & wmask_q);
            default: waddr_next = waddr_q + MEM_AW'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = (LATENCY > 1) ? StWait : StBurst;
                end
            end
            StWait: begin
                if (wait_q == 8'd0) state_d = StBurst;
            end
            StBurst: begin
                if (rvalid_o && rready_i && rlast_o) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            resp_q  <= '0;
            burst_q <= '0;
            waddr_q <= '0;
            wmask_q <= '0;
            beats_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                id_q    <= head.id;
                resp_q  <= head.resp;
                burst_q <= head.burst;
                waddr_q <= head.word;
                wmask_q <= MEM_AW'(head.len);
                beats_q <= {1'b0, head.len} + 5'd1;
                wait_q  <= WaitLoad;
            end else begin
                if ((state_q == StWait) && (wait_q != 8'd0)) wait_q <= wait_q - 8'd1;
                if (issue) begin
                    waddr_q <= waddr_next;
                    beats_q <= beats_q - 5'd1;
                end
            end
        end
    end

    // ---------------- R pipeline: read stage, skid slot, output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_last_q  <= 1'b0;
            sk_data_q  <= '0;
            rvalid_o   <= 1'b0;
            rlast_o    <= 1'b0;
            rid_o      <= '0;
            rresp_o    <= '0;
            rdata_o    <= '0;
        end else begin
            p1_valid_q <= issue;
            p1_last_q  <= (beats_q == 5'd1);
            if (r_free) begin
                if (sk_valid_q) begin
                    rvalid_o   <= 1'b1;
                    rlast_o    <= sk_last_q;
                    rdata_o    <= sk_data_q;
                    rid_o      <= id_q;
                    rresp_o    <= resp_q;
                    sk_valid_q <= p1_valid_q;
                    if (p1_valid_q) begin
                        sk_data_q <= beat_data;
                        sk_last_q <= p1_last_q;
                    end
                end else if (p1_valid_q) begin
                    rvalid_o <= 1'b1;
                    rlast_o  <= p1_last_q;
                    rdata_o  <= beat_data;
                    rid_o    <= id_q;
                    rresp_o  <= resp_q;
                end else begin
                    rvalid_o <= 1'b0;
                    rlast_o  <= 1'b0;
                end
            end else if (p1_valid_q) begin
                sk_valid_q <= 1'b1;
                sk_data_q  <= beat_data;
                sk_last_q  <= p1_last_q;
            end
        end
    end

endmodule
